// File: rtl/calc_pkg.sv
// calc_pkg: op and FSM state encodings shared by the sequential calculator
package calc_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;
endpackage

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: one-bit-per-step shift-add multiplier / restoring divider sharing one 2*WIDTH register
module calc_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   b_q, b_d, rem;
  logic               mode_q, mode_d, ge;
  logic [WIDTH:0]     sum, trial;
  // p_q holds {acc, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    trial  = p_q[2*WIDTH-1:WIDTH-1];
    ge     = trial >= {1'b0, b_q};
    rem    = ge ? trial[WIDTH-1:0] - b_q : trial[WIDTH-1:0];
    p_d    = p_q;
    b_d    = b_q;
    mode_d = mode_q;
    if (start) begin
      p_d    = {{WIDTH{1'b0}}, a};
      b_d    = b;
      mode_d = mode;
    end else if (step) begin
      p_d = mode_q ? {rem, p_q[WIDTH-2:0], ge} : {sum, p_q[WIDTH-1:1]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      b_q    <= b_d;
      mode_q <= mode_d;
    end
  end
  assign result = p_q;
endmodule

// File: rtl/calc_seq_core.sv
// calc_seq_core: valid/ready arithmetic core; add/sub in one cycle, mul/div iterated one bit per cycle
module calc_seq_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               pend_q, pend_d, live_q, use_iter_q, use_iter_d, dbz_q, dbz_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] res_q, res_d, iter_res;
  logic               accept, iter_go, start;
  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready = ena && live_q && state_q == ST_IDLE && !pend_q;
  assign accept   = in_valid && in_ready;
  assign iter_go  = op_q == OP_MUL || (op_q == OP_DIV && b_q != '0);
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    dbz_d      = dbz_q;
    use_iter_d = use_iter_q;
    start      = 1'b0;
    if (accept) begin
      pend_d = 1'b1;
      op_d   = op_e'(op);
      a_d    = a;
      b_d    = b;
      dbz_d  = 1'b0;
    end else if (ena && pend_q) begin
      pend_d     = 1'b0;
      start      = iter_go;
      use_iter_d = iter_go;
      state_d    = iter_go ? ST_EXEC : ST_DONE;
      cnt_d      = iter_go ? CW'(WIDTH) : '0;
      dbz_d      = !iter_go && op_q == OP_DIV;
      res_d      = op_q == OP_ADD ? {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q} :
                   op_q == OP_SUB ? {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q} :
                   iter_go        ? res_q : {a_q, {WIDTH{1'b1}}};
    end else if (ena && state_q == ST_EXEC) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? ST_DONE : ST_EXEC;
    end else if (ena && state_q == ST_DONE && out_ready) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      pend_q     <= 1'b0;
      live_q     <= 1'b0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      dbz_q      <= 1'b0;
      use_iter_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pend_q     <= pend_d;
      live_q     <= 1'b1;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      dbz_q      <= dbz_d;
      use_iter_q <= use_iter_d;
    end
  end
  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .step   (ena && state_q == ST_EXEC),
    .mode   (op_q[0]),
    .a      (a_q),
    .b      (b_q),
    .result (iter_res)
  );
  assign result      = use_iter_q ? iter_res : res_q;
  assign div_by_zero = dbz_q;
  assign out_valid   = state_q == ST_DONE;
  assign busy        = state_q == ST_EXEC;
endmodule

// File: tb/tb_calc_seq_core.sv
// tb_calc_seq_core: directed WIDTH=8 scenarios plus randomized WIDTH=16 scoreboard run
module tb_calc_seq_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;

  logic e8 = 1'b1, iv8 = 1'b0, or8 = 1'b0, ir8, ov8, bz8, by8;
  logic [1:0] op8 = 2'd0;
  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic [15:0] r8;
  calc_seq_core #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .ena(e8), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .result(r8), .div_by_zero(bz8), .busy(by8)
  );

  logic e16 = 1'b1, iv16 = 1'b0, or16 = 1'b0, ir16, ov16, bz16, by16;
  logic [1:0] op16 = 2'd0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic [31:0] r16;
  calc_seq_core #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .ena(e16), .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .result(r16), .div_by_zero(bz16), .busy(by16)
  );

  task automatic issue8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    @(negedge clk);
    while (!ir8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    op8 = o; a8 = x; b8 = y; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
  endtask

  task automatic wait_out8(output int lat, output int bc);
    lat = 0;
    bc = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (by8) bc++;
    end while (!ov8 && lat < 100);
  endtask

  task automatic take8();
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ir8, ov8, by8, bz8, r8} !== 20'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {ir8, ov8, by8, bz8, r8}); end
    checks++;
    if ({ir16, ov16, by16, bz16, r16} !== 36'h0) begin failures++; $display("FAIL reset_outputs16 got=%h exp=0", {ir16, ov16, by16, bz16, r16}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ir8 !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b exp=0", ir8); end
    @(posedge clk);
    #1;
    checks++;
    if (ir8 !== 1'b1) begin failures++; $display("FAIL ready_after_edge got=%b exp=1", ir8); end
  endtask

  task automatic test_addsub();
    int lat, bc;
    issue8(2'b00, 8'hFF, 8'h01);
    wait_out8(lat, bc);
    checks++;
    if (r8 !== 16'h0100 || lat != 1 || bz8 !== 1'b0) begin failures++; $display("FAIL add got=%h lat=%0d exp=0100 lat=1", r8, lat); end
    take8();
    checks++;
    if (ov8 !== 1'b0) begin failures++; $display("FAIL add_drop got=%b exp=0", ov8); end
    issue8(2'b01, 8'h03, 8'h05);
    wait_out8(lat, bc);
    checks++;
    if (r8 !== 16'hFFFE || lat != 1) begin failures++; $display("FAIL sub got=%h lat=%0d exp=FFFE lat=1", r8, lat); end
    take8();
  endtask

  task automatic test_mul();
    int lat, bc;
    issue8(2'b10, 8'hFF, 8'hFF);
    wait_out8(lat, bc);
    checks++;
    if (r8 !== 16'hFE01) begin failures++; $display("FAIL mul got=%h exp=FE01", r8); end
    checks++;
    if (lat != 9 || bc != 8) begin failures++; $display("FAIL mul_timing got lat=%0d busy=%0d exp lat=9 busy=8", lat, bc); end
    take8();
  endtask

  task automatic test_div();
    int lat, bc;
    issue8(2'b11, 8'd200, 8'd7);
    wait_out8(lat, bc);
    checks++;
    if (r8 !== 16'h041C || lat != 9 || bz8 !== 1'b0) begin failures++; $display("FAIL div got=%h lat=%0d dbz=%b exp=041C lat=9 dbz=0", r8, lat, bz8); end
    take8();
    issue8(2'b11, 8'd5, 8'd0);
    wait_out8(lat, bc);
    checks++;
    if (r8 !== 16'h05FF || lat != 1 || bz8 !== 1'b1) begin failures++; $display("FAIL div0 got=%h lat=%0d dbz=%b exp=05FF lat=1 dbz=1", r8, lat, bz8); end
    take8();
    issue8(2'b00, 8'd1, 8'd1);
    wait_out8(lat, bc);
    checks++;
    if (bz8 !== 1'b0 || r8 !== 16'h0002) begin failures++; $display("FAIL dbz_clear got=%b/%h exp=0/0002", bz8, r8); end
    take8();
  endtask

  task automatic test_backpressure();
    int lat, bc;
    issue8(2'b00, 8'h10, 8'h20);
    wait_out8(lat, bc);
    @(negedge clk);
    op8 = 2'b01; a8 = 8'd9; b8 = 8'd4; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (r8 !== 16'h0030 || ov8 !== 1'b1 || ir8 !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%h ov=%b rdy=%b exp=0030 1 0", i, r8, ov8, ir8); end
    end
    take8();
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin failures++; $display("FAIL bp_release got ov=%b rdy=%b exp 0 1", ov8, ir8); end
    @(posedge clk);
    #1 iv8 = 1'b0;
    wait_out8(lat, bc);
    checks++;
    if (r8 !== 16'h0005 || lat != 1) begin failures++; $display("FAIL bp_next got=%h lat=%0d exp=0005 lat=1", r8, lat); end
    take8();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov8 !== 1'b0) begin failures++; $display("FAIL bp_nodup got=%b exp=0", ov8); end
  endtask

  task automatic test_ena_stall();
    int lat = 0;
    issue8(2'b10, 8'hAB, 8'hCD);
    repeat (3) begin @(posedge clk); #1; lat++; end
    e8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    e8 = 1'b1;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (r8 !== 16'h88EF || lat != 12) begin failures++; $display("FAIL ena_stall got=%h lat=%0d exp=88EF lat=12", r8, lat); end
    take8();
  endtask

  task automatic test_reset_mid_div();
    int lat, bc;
    issue8(2'b11, 8'd250, 8'd3);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ir8, ov8, by8, bz8, r8} !== 20'h0) begin failures++; $display("FAIL reset_mid got=%h exp=0", {ir8, ov8, by8, bz8, r8}); end
    @(negedge clk);
    rst_n = 1'b1;
    issue8(2'b11, 8'd250, 8'd3);
    wait_out8(lat, bc);
    checks++;
    if (r8 !== 16'h0153 || lat != 9) begin failures++; $display("FAIL after_reset got=%h lat=%0d exp=0153 lat=9", r8, lat); end
    take8();
  endtask

  task automatic test_random16();
    logic [31:0] q_res[$];
    logic q_dbz[$];
    logic [1:0] o;
    logic [15:0] x, y;
    logic [31:0] er;
    logic eb;
    int sent = 0, got = 0, cyc = 0;
    const int N = 1000;
    o = 2'($urandom); x = 16'($urandom); y = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
    while ((sent < N || got < sent) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      e16 = $urandom_range(0, 9) < 8;
      iv16 = sent < N && $urandom_range(0, 9) < 7;
      or16 = $urandom_range(0, 9) < 6;
      op16 = o; a16 = x; b16 = y;
      #1;
      if (ov16 && or16 && e16) begin
        checks++;
        if (q_res.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra got=%h exp=none", r16);
        end else begin
          er = q_res.pop_front();
          eb = q_dbz.pop_front();
          got++;
          if (r16 !== er || bz16 !== eb) begin failures++; $display("FAIL rnd_result%0d got=%h/%b exp=%h/%b", got, r16, bz16, er, eb); end
        end
      end
      if (iv16 && ir16) begin
        case (o)
          2'd0: er = {16'h0, x} + {16'h0, y};
          2'd1: er = {16'h0, x} - {16'h0, y};
          2'd2: er = 32'(x) * 32'(y);
          default: er = (y == 16'h0) ? {x, 16'hFFFF} : {x % y, x / y};
        endcase
        q_res.push_back(er);
        q_dbz.push_back(o == 2'd3 && y == 16'h0);
        sent++;
        o = 2'($urandom); x = 16'($urandom); y = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      end
    end
    e16 = 1'b1; iv16 = 1'b0; or16 = 1'b0;
    checks++;
    if (got != N || q_res.size() != 0) begin failures++; $display("FAIL rnd_count got=%0d pending=%0d exp=%0d/0", got, q_res.size(), N); end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_backpressure();
    test_ena_stall();
    test_reset_mid_div();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
